// File: rtl/pic_pkg.sv
// Shared types and bit positions for the PIC command sequencer.
// Holds the init-sequence state enum, the read-select enum and command bit indices.
package pic_pkg;

    typedef enum logic [2:0] {
        S_UNINIT,
        S_ICW2,
        S_ICW3,
        S_ICW4,
        S_READY
    } pic_state_e;

    typedef enum logic {
        RSEL_IRR,
        RSEL_ISR
    } rsel_e;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int CMD_ICW1  = 4;
    localparam int CMD_OCW3  = 3;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_RIS  = 0;
    localparam int OCW3_P    = 2;

    // State reached after the ICW accepted in state s, given the latched ICW1.
    function automatic pic_state_e after_icw(pic_state_e s, logic [7:0] icw1);
        pic_state_e n;
        n = S_READY;
        case (s)
            S_ICW2: begin
                if (!icw1[ICW1_SNGL])
                    n = S_ICW3;
                else if (icw1[ICW1_IC4])
                    n = S_ICW4;
            end
            S_ICW3: begin
                if (icw1[ICW1_IC4])
                    n = S_ICW4;
            end
            default: n = S_READY;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pic_cmd_sequencer_if.sv
// CPU-side bus of the PIC: strobes, address bit, write data and read data.
// master = CPU/bus buffer side, slave = pic_cmd_sequencer.
interface pic_bus_if #(
    parameter int DATA_W = 8
);
    logic              cs_n;
    logic              rd_n;
    logic              wr_n;
    logic              a0;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              dout_oe;

    modport master (
        output cs_n, rd_n, wr_n, a0, din,
        input  dout, dout_oe
    );

    modport slave (
        input  cs_n, rd_n, wr_n, a0, din,
        output dout, dout_oe
    );
endinterface

// File: rtl/pic_strobe_sync.sv
// Synchronises cs_n/rd_n/wr_n/a0/din and turns strobe rising edges into commit triggers.
// Ports: clk, rst_n, raw bus pins in; wr_cmt (and rd_cmt with PIC_POLL_CMD_EN), captured a0/din out.
module pic_strobe_sync #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              a0,
    input  logic [DATA_W-1:0] din,
    output logic              wr_cmt,
`ifdef PIC_POLL_CMD_EN
    output logic              rd_cmt,
`endif
    output logic              cap_a0,
    output logic [DATA_W-1:0] cap_din
);
    localparam int W = DATA_W + 4;
    localparam logic [W-1:0] IDLE = {3'b111, {(DATA_W + 1){1'b0}}};

    logic [W-1:0]      pipe [SYNC_STAGES];
    logic              cs_s, rd_s, wr_s, a0_s;
    logic [DATA_W-1:0] din_s;
    logic              wr_q;
    logic              cap_cs_n;

    assign {cs_s, rd_s, wr_s, a0_s, din_s} = pipe[SYNC_STAGES-1];

    // Capture keeps the last bus values seen while a strobe was low,
    // so data changing together with the strobe rise is not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                pipe[i] <= IDLE;
            wr_q     <= 1'b1;
            cap_cs_n <= 1'b1;
            cap_a0   <= 1'b0;
            cap_din  <= '0;
        end else begin
            pipe[0] <= {cs_n, rd_n, wr_n, a0, din};
            for (int i = 1; i < SYNC_STAGES; i++)
                pipe[i] <= pipe[i-1];
            wr_q <= wr_s;
            if (!wr_s || !rd_s) begin
                cap_cs_n <= cs_s;
                cap_a0   <= a0_s;
                cap_din  <= din_s;
            end
        end
    end

    assign wr_cmt = wr_s & ~wr_q & ~cap_cs_n;

`ifdef PIC_POLL_CMD_EN
    logic rd_q;
    logic ovl;

    // ovl marks a read cycle that overlapped a write; such reads have no side effects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= 1'b1;
            ovl  <= 1'b0;
        end else begin
            rd_q <= rd_s;
            if (!rd_s && !wr_s)
                ovl <= 1'b1;
            else if (rd_s && wr_s)
                ovl <= 1'b0;
        end
    end

    assign rd_cmt = rd_s & ~rd_q & ~cap_cs_n & ~cap_a0 & ~ovl;
`endif
endmodule

// File: rtl/pic_cmd_sequencer.sv
// PIC command front-end: ICW1..ICW4 init sequence, OCW1/2/3 decode, config registers, read mux.
// Ports: clk, rst_n, bus (pic_bus_if.slave), irr_i/isr_i in; icw1_q..icw4_q, imr_q, init_done,
// ocw2_stb/ocw2_q, init_stb out. Define PIC_POLL_CMD_EN for OCW3 poll mode and the poll_ack output.
module pic_cmd_sequencer
    import pic_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    pic_bus_if.slave          bus,
    input  logic [DATA_W-1:0] irr_i,
    input  logic [DATA_W-1:0] isr_i,
    output logic [7:0]        icw1_q,
    output logic [7:0]        icw2_q,
    output logic [7:0]        icw3_q,
    output logic [7:0]        icw4_q,
    output logic [DATA_W-1:0] imr_q,
    output logic              init_done,
    output logic              ocw2_stb,
    output logic [7:0]        ocw2_q,
`ifdef PIC_POLL_CMD_EN
    output logic              poll_ack,
`endif
    output logic              init_stb
);
    logic              wr_cmt;
    logic              cap_a0;
    logic [DATA_W-1:0] cap_din;
    logic [7:0]        d8;
    pic_state_e        state;
    pic_state_e        nxt;
    rsel_e             rsel;
    logic              ready;
    logic              is_icw1, ocw2_ok, ocw3_ok;

`ifdef PIC_POLL_CMD_EN
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    logic              rd_cmt;
    logic              poll_pending;
    logic [DATA_W-1:0] req;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] poll_word;
`endif

    pic_strobe_sync #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .cs_n    (bus.cs_n),
        .rd_n    (bus.rd_n),
        .wr_n    (bus.wr_n),
        .a0      (bus.a0),
        .din     (bus.din),
        .wr_cmt  (wr_cmt),
`ifdef PIC_POLL_CMD_EN
        .rd_cmt  (rd_cmt),
`endif
        .cap_a0  (cap_a0),
        .cap_din (cap_din)
    );

    assign d8      = cap_din[7:0];
    assign ready   = (state == S_READY);
    assign nxt     = after_icw(state, icw1_q);
    assign is_icw1 = ~cap_a0 & d8[CMD_ICW1];
    assign ocw2_ok = ready & ~cap_a0 & ~d8[CMD_ICW1] & ~d8[CMD_OCW3];
    assign ocw3_ok = ready & ~cap_a0 & ~d8[CMD_ICW1] & d8[CMD_OCW3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_UNINIT;
            icw1_q    <= '0;
            icw2_q    <= '0;
            icw3_q    <= '0;
            icw4_q    <= '0;
            imr_q     <= '0;
            ocw2_q    <= '0;
            rsel      <= RSEL_IRR;
            init_done <= 1'b0;
            ocw2_stb  <= 1'b0;
            init_stb  <= 1'b0;
`ifdef PIC_POLL_CMD_EN
            poll_pending <= 1'b0;
            poll_ack     <= 1'b0;
`endif
        end else begin
            ocw2_stb <= 1'b0;
            init_stb <= 1'b0;
`ifdef PIC_POLL_CMD_EN
            poll_ack <= 1'b0;
            if (rd_cmt && poll_pending) begin
                poll_pending <= 1'b0;
                poll_ack     <= 1'b1;
            end
`endif
            if (wr_cmt) begin
                unique case (1'b1)
                    is_icw1: begin
                        state     <= S_ICW2;
                        icw1_q    <= d8;
                        if (!d8[ICW1_IC4])
                            icw4_q <= '0;
                        imr_q     <= '0;
                        rsel      <= RSEL_IRR;
                        init_done <= 1'b0;
                        init_stb  <= 1'b1;
`ifdef PIC_POLL_CMD_EN
                        poll_pending <= 1'b0;
`endif
                    end
                    cap_a0: begin
                        case (state)
                            S_ICW2: begin
                                icw2_q <= d8;
                                state  <= nxt;
                                if (nxt == S_READY)
                                    init_done <= 1'b1;
                            end
                            S_ICW3: begin
                                icw3_q <= d8;
                                state  <= nxt;
                                if (nxt == S_READY)
                                    init_done <= 1'b1;
                            end
                            S_ICW4: begin
                                icw4_q    <= d8;
                                state     <= S_READY;
                                init_done <= 1'b1;
                            end
                            S_READY: imr_q <= cap_din;
                            default: ;
                        endcase
                    end
                    ocw2_ok: begin
                        ocw2_q   <= d8;
                        ocw2_stb <= 1'b1;
                    end
                    ocw3_ok: begin
                        if (d8[OCW3_RR])
                            rsel <= d8[OCW3_RIS] ? RSEL_ISR : RSEL_IRR;
`ifdef PIC_POLL_CMD_EN
                        if (d8[OCW3_P])
                            poll_pending <= 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PIC_POLL_CMD_EN
    // Lowest index wins: IR0 has the highest priority.
    always_comb begin
        req = irr_i & ~imr_q;
        idx = '0;
        for (int i = DATA_W - 1; i >= 0; i--)
            if (req[i])
                idx = i[IW-1:0];
        poll_word = '0;
        poll_word[DATA_W-1] = |req;
        poll_word[IW-1:0] = idx;
    end
`endif

    always_comb begin
        if (bus.a0)
            bus.dout = imr_q;
        else if (rsel == RSEL_ISR)
            bus.dout = isr_i;
        else
            bus.dout = irr_i;
`ifdef PIC_POLL_CMD_EN
        if (!bus.a0 && poll_pending)
            bus.dout = poll_word;
`endif
    end

    assign bus.dout_oe = ~bus.cs_n & ~bus.rd_n & bus.wr_n;
endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Self-checking bench for pic_cmd_sequencer: directed init/OCW steps then random bus traffic.
// Expected values come from a queue-based model of the init sequence and command rules.
module tb_pic_cmd_sequencer;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pic_bus_if #(.DATA_W(DW)) bus ();

    logic [DW-1:0] irr_i, isr_i, imr_q;
    logic [7:0]    icw1_q, icw2_q, icw3_q, icw4_q, ocw2_q;
    logic          init_done, ocw2_stb, init_stb;
`ifdef PIC_POLL_CMD_EN
    logic          poll_ack;
`endif

    pic_cmd_sequencer #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .irr_i     (irr_i),
        .isr_i     (isr_i),
        .icw1_q    (icw1_q),
        .icw2_q    (icw2_q),
        .icw3_q    (icw3_q),
        .icw4_q    (icw4_q),
        .imr_q     (imr_q),
        .init_done (init_done),
        .ocw2_stb  (ocw2_stb),
        .ocw2_q    (ocw2_q),
`ifdef PIC_POLL_CMD_EN
        .poll_ack  (poll_ack),
`endif
        .init_stb  (init_stb)
    );

    int total = 0;
    int bad = 0;

    // strobe high-cycle counters; a pulse longer than one cycle over-counts
    int n_ocw2 = 0, n_init = 0, n_poll = 0;
    always @(posedge clk) begin
        if (ocw2_stb) n_ocw2++;
        if (init_stb) n_init++;
`ifdef PIC_POLL_CMD_EN
        if (poll_ack) n_poll++;
`endif
    end

    // reference model
    logic [7:0]    m_icw [1:4];
    logic [DW-1:0] m_imr;
    logic [7:0]    m_ocw2;
    bit            m_isr_sel, m_poll, m_seen;
    int            pend[$];
    int            e_ocw2 = 0, e_init = 0, e_poll = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 1; k <= 4; k++) m_icw[k] = 8'h00;
        m_imr = '0;
        m_ocw2 = 8'h00;
        m_isr_sel = 0;
        m_poll = 0;
        m_seen = 0;
        pend.delete();
    endfunction

    function automatic bit m_ready();
        return m_seen && (pend.size() == 0);
    endfunction

    function automatic void model_write(input bit a, input logic [7:0] d);
        int k;
        if (!a && d[4]) begin
            m_icw[1] = d;
            if (!d[0]) m_icw[4] = 8'h00;
            m_imr = '0;
            m_isr_sel = 0;
            m_poll = 0;
            m_seen = 1;
            pend.delete();
            pend.push_back(2);
            if (!d[1]) pend.push_back(3);
            if (d[0]) pend.push_back(4);
            e_init++;
        end else if (a) begin
            if (pend.size() > 0) begin
                k = pend.pop_front();
                m_icw[k] = d;
            end else if (m_seen) begin
                m_imr = d;
            end
        end else if (m_ready()) begin
            if (d[3] == 1'b0) begin
                m_ocw2 = d;
                e_ocw2++;
            end else begin
                if (d[1]) m_isr_sel = d[0];
`ifdef PIC_POLL_CMD_EN
                if (d[2]) m_poll = 1;
`endif
            end
        end
    endfunction

    function automatic logic [7:0] poll_word();
        logic [7:0] req, w;
        req = irr_i & ~m_imr;
        w = 8'h00;
        if (req != 0) begin
            w[7] = 1'b1;
            for (int i = 7; i >= 0; i--)
                if (req[i]) w[2:0] = 3'(i);
        end
        return w;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".icw1"}, icw1_q, m_icw[1]);
        chk({tag, ".icw2"}, icw2_q, m_icw[2]);
        chk({tag, ".icw3"}, icw3_q, m_icw[3]);
        chk({tag, ".icw4"}, icw4_q, m_icw[4]);
        chk({tag, ".imr"}, imr_q, m_imr);
        chk({tag, ".ocw2"}, ocw2_q, m_ocw2);
        chk({tag, ".init_done"}, init_done, m_ready());
        chk({tag, ".n_ocw2"}, n_ocw2, e_ocw2);
        chk({tag, ".n_init"}, n_init, e_init);
`ifdef PIC_POLL_CMD_EN
        chk({tag, ".n_poll"}, n_poll, e_poll);
`endif
    endtask

    task automatic do_write(input bit a, input logic [7:0] d, input bit cs);
        @(negedge clk);
        bus.cs_n = cs;
        bus.a0 = a;
        bus.din = d;
        bus.wr_n = 1'b0;
        repeat (3) @(negedge clk);
        bus.wr_n = 1'b1;
        repeat (4) @(negedge clk);
        bus.cs_n = 1'b1;
        if (!cs) model_write(a, d);
    endtask

    task automatic do_read(input string tag, input bit a);
        logic [7:0] exp;
        @(negedge clk);
        bus.cs_n = 1'b0;
        bus.a0 = a;
        bus.rd_n = 1'b0;
        if (a) exp = m_imr;
        else if (m_poll) exp = poll_word();
        else exp = m_isr_sel ? isr_i : irr_i;
        #1;
        chk({tag, ".dout"}, bus.dout, exp);
        chk({tag, ".oe"}, bus.dout_oe, 1'b1);
        repeat (3) @(negedge clk);
        bus.rd_n = 1'b1;
        repeat (4) @(negedge clk);
        bus.cs_n = 1'b1;
        if (!a && m_poll) begin
            m_poll = 0;
            e_poll++;
        end
    endtask

    initial begin
        bus.cs_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.a0 = 1'b0;
        bus.din = '0;
        irr_i = 8'h5A;
        isr_i = 8'hC3;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset.ocw2_stb", ocw2_stb, 1'b0);
        chk("reset.init_stb", init_stb, 1'b0);
        rst_n = 1'b1;

        do_read("rst_rd", 1'b0);
        do_write(1'b1, 8'hAA, 1'b0);
        check_all("uninit_ocw1");
        chk("uninit_imr", imr_q, 8'h00);

        // single, IC4: ICW3 skipped
        do_write(1'b0, 8'h13, 1'b0);
        check_all("a_icw1");
        do_write(1'b1, 8'h20, 1'b0);
        check_all("a_icw2");
        chk("a_done2", init_done, 1'b0);
        do_write(1'b1, 8'h01, 1'b0);
        check_all("a_icw4");
        chk("a_done", init_done, 1'b1);
        chk("a_icw2v", icw2_q, 8'h20);

        // OCW1 with latency probe
        @(negedge clk);
        bus.cs_n = 1'b0;
        bus.a0 = 1'b1;
        bus.din = 8'hF0;
        bus.wr_n = 1'b0;
        repeat (3) @(negedge clk);
        bus.wr_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("lat_early", imr_q, 8'h00);
        @(posedge clk); #1;
        chk("lat_commit", imr_q, 8'hF0);
        repeat (3) @(negedge clk);
        bus.cs_n = 1'b1;
        model_write(1'b1, 8'hF0);
        check_all("ocw1");

        do_write(1'b0, 8'h0B, 1'b0);
        do_read("rd_isr", 1'b0);
        do_read("rd_imr", 1'b1);
        do_write(1'b0, 8'h0A, 1'b0);
        do_read("rd_irr", 1'b0);
        do_write(1'b0, 8'h20, 1'b0);
        check_all("ocw2");

        // cascaded with ICW4
        do_write(1'b0, 8'h11, 1'b0);
        do_write(1'b1, 8'h40, 1'b0);
        do_write(1'b1, 8'h04, 1'b0);
        check_all("b_icw3");
        chk("b_done3", init_done, 1'b0);
        do_write(1'b1, 8'h01, 1'b0);
        check_all("b_icw4");
        chk("b_icw3v", icw3_q, 8'h04);

        // restart mid-sequence, OCW2 ignored while initialising
        do_write(1'b1, 8'h77, 1'b0);
        do_write(1'b0, 8'h13, 1'b0);
        do_write(1'b1, 8'h08, 1'b0);
        do_write(1'b0, 8'h12, 1'b0);
        check_all("restart");
        chk("restart_imr", imr_q, 8'h00);
        do_write(1'b0, 8'h20, 1'b0);
        check_all("mid_ocw2");
        do_write(1'b1, 8'h48, 1'b0);
        check_all("c_icw2");

        // simultaneous rd/wr: write wins, no drive
        @(negedge clk);
        bus.cs_n = 1'b0;
        bus.a0 = 1'b1;
        bus.din = 8'h5A;
        bus.rd_n = 1'b0;
        bus.wr_n = 1'b0;
        #1;
        chk("ovl_oe", bus.dout_oe, 1'b0);
        repeat (3) @(negedge clk);
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        repeat (4) @(negedge clk);
        bus.cs_n = 1'b1;
        model_write(1'b1, 8'h5A);
        check_all("ovl");

        do_write(1'b1, 8'h33, 1'b1);
        check_all("cs_high");

`ifdef PIC_POLL_CMD_EN
        do_write(1'b1, 8'h00, 1'b0);
        irr_i = 8'h08;
        do_write(1'b0, 8'h0C, 1'b0);
        // overlapped rd/wr must not consume the pending poll
        @(negedge clk);
        bus.cs_n = 1'b0;
        bus.a0 = 1'b0;
        bus.din = 8'h08;
        bus.rd_n = 1'b0;
        bus.wr_n = 1'b0;
        repeat (3) @(negedge clk);
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        repeat (4) @(negedge clk);
        bus.cs_n = 1'b1;
        model_write(1'b0, 8'h08);
        chk("poll_word", poll_word(), 8'h83);
        do_read("poll_rd", 1'b0);
        check_all("poll");
        do_read("poll_after", 1'b0);
`endif

        // reset in the middle of a sequence takes effect immediately
        do_write(1'b0, 8'h11, 1'b0);
        do_write(1'b1, 8'h60, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int it = 0; it < 80; it++) begin
            int r;
            bit cs;
            logic [7:0] d;
            r = $urandom_range(0, 9);
            cs = ($urandom_range(0, 9) == 0);
            d = 8'($urandom);
            irr_i = 8'($urandom);
            isr_i = 8'($urandom);
            if (r == 0)
                do_write(1'b0, d | 8'h10, cs);
            else if (r <= 4)
                do_write(1'b1, d, cs);
            else if (r <= 6)
                do_write(1'b0, d & 8'hEF, cs);
            else
                do_read("rnd_rd", r[0]);
            check_all("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
